serial_addsub_unit: RTL and testbench

Multi-cycle, digit-serial adder/subtractor/comparator for the Mini-MIPS datapath. It processes `DIGIT` bits per clock over `WIDTH/DIGIT` cycles, trading latency for area, and exposes valid/ready handshakes on both sides so the multi-cycle control unit can stall it. It produces sum, carry, overflow, signed/unsigned less-than and zero flags for ADD, SUB, SLT and SLTU.

---
 rtl/addsub_pkg.sv | 26 ++
 rtl/addsub_digit.sv | 37 +++
 rtl/serial_addsub_unit.sv | 183 ++++++++++++++++++
 tb/tb_serial_addsub_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types for the digit-serial add/sub/compare unit.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: op_t operation encoding (matches the 2-bit op port) and the
//           state_t FSM states used by serial_addsub_unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_SLT  = 2'b10,
    OP_SLTU = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Every operation except ADD runs as a + ~b + 1.
  function automatic logic is_subtract(op_t op);
    return op != OP_ADD;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Purpose: one DIGIT-bit slice of a ripple adder, reused every serial cycle.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: x, y  - addend digits
//        ci    - carry into bit 0
//        s     - sum digit
//        co    - carry out of the top bit
//        c_msb - carry into the top bit (feeds signed-overflow detection)
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] full;

  assign full  = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  assign s     = full[DIGIT-1:0];
  assign co    = full[DIGIT];

  generate
    if (DIGIT == 1) begin : g_single
      assign c_msb = ci;
    end else begin : g_multi
      // Sum of the bits below the top one; its top bit is the carry into the MSB.
      logic [DIGIT-1:0] low;
      assign low   = {1'b0, x[DIGIT-2:0]} + {1'b0, y[DIGIT-2:0]} + {{(DIGIT-1){1'b0}}, ci};
      assign c_msb = low[DIGIT-1];
    end
  endgenerate

endmodule

// File: rtl/serial_addsub_unit.sv
// Purpose: digit-serial ADD/SUB/SLT/SLTU with carry/overflow/less/zero flags.
// Latency: out_valid rises N = WIDTH/DIGIT cycles after the accept edge.
// Backpressure: result held in DONE until out_ready; in_valid ignored while busy.
// Ports: clk, rst_n (async active-low)
//        in_valid/in_ready + a, b, op, cin   - operation request
//        out_valid/out_ready + result, carry, overflow, less, zero - response
module serial_addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             less,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  op_t                    op_q, op_d;
  logic                   cy_q, cy_d;
  // Upper WIDTH-DIGIT bits of the sum; the digit in flight completes the word.
  logic [WIDTH-DIGIT-1:0] sum_q, sum_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   carry_q, carry_d;
  logic                   overflow_q, overflow_d;
  logic                   less_q, less_d;
  logic                   zero_q, zero_d;

  logic [DIGIT-1:0]       dig_s;
  logic                   dig_co;
  logic                   dig_cmsb;
  logic [WIDTH-1:0]       sum_full;
  logic                   accept;
  logic                   ovf_fin;
  logic                   less_fin;
  logic [WIDTH-1:0]       res_fin;
  op_t                    op_in;

  // Operands shift right one digit per cycle, so the active digit is always at the bottom.
  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .x     (a_q[DIGIT-1:0]),
    .y     (b_q[DIGIT-1:0]),
    .ci    (cy_q),
    .s     (dig_s),
    .co    (dig_co),
    .c_msb (dig_cmsb)
  );

  assign sum_full = {dig_s, sum_q};
  assign op_in    = op_t'(op);

  // Flag evaluation for the final digit; only meaningful when k_q == K_LAST.
  always_comb begin
    ovf_fin  = dig_co ^ dig_cmsb;
    less_fin = 1'b0;
    case (op_q)
      OP_SUB, OP_SLT: less_fin = ovf_fin ^ sum_full[WIDTH-1];
      OP_SLTU:        less_fin = ~dig_co;
      default:        less_fin = 1'b0;
    endcase
    res_fin = sum_full;
    if (op_q == OP_SLT || op_q == OP_SLTU) begin
      res_fin = {{(WIDTH-1){1'b0}}, less_fin};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cy_d       = cy_q;
    sum_d      = sum_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    less_d     = less_q;
    zero_d     = zero_q;

    in_ready = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
    accept   = in_valid && in_ready;

    case (state_q)
      S_RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        cy_d  = dig_co;
        sum_d = sum_full[WIDTH-1:DIGIT];
        k_d   = k_q + KW'(1);
        if (k_q == K_LAST) begin
          result_d   = res_fin;
          carry_d    = dig_co;
          overflow_d = ovf_fin;
          less_d     = less_fin;
          zero_d     = (res_fin == '0);
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Acceptance overrides the above, covering both IDLE and the DONE fast path.
    if (accept) begin
      a_d     = a;
      b_d     = is_subtract(op_in) ? ~b : b;
      op_d    = op_in;
      cy_d    = is_subtract(op_in) ? 1'b1 : cin;
      k_d     = '0;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      cy_q       <= 1'b0;
      sum_q      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      less_q     <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      k_q        <= k_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      cy_q       <= cy_d;
      sum_q      <= sum_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      less_q     <= less_d;
      zero_q     <= zero_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign less      = less_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Bench for serial_addsub_unit: 32/4 instance with scoreboard plus an 8/2 instance.
// Latency: checks N-cycle result latency and N+1-cycle back-to-back throughput.
// Backpressure: holds out_ready low in DONE and checks outputs stay frozen.
module tb_serial_addsub_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [1:0]  op;
  logic        cin, carry, overflow, less, zero;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, result8;
  logic [1:0]  op8;
  logic        cin8, carry8, overflow8, less8, zero8;

  serial_addsub_unit #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow), .less(less), .zero(zero)
  );

  serial_addsub_unit #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .carry(carry8), .overflow(overflow8), .less(less8), .zero(zero8)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_acc  = 0;
  int last_wait = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] result;
    logic        carry;
    logic        overflow;
    logic        less;
    logic        zero;
    int          acc;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: overflow by operand/result signs, less by native compares.
  function automatic exp_t model(input logic [1:0] op_v, input logic [31:0] a_v,
                                 input logic [31:0] b_v, input logic cin_v);
    exp_t        e;
    logic [31:0] bb;
    logic        c0;
    logic [32:0] full;
    bb   = (op_v == 2'b00) ? b_v : ~b_v;
    c0   = (op_v == 2'b00) ? cin_v : 1'b1;
    full = {1'b0, a_v} + {1'b0, bb} + {32'b0, c0};
    e.carry    = full[32];
    e.overflow = (a_v[31] == bb[31]) && (full[31] != a_v[31]);
    case (op_v)
      2'b00:        e.less = 1'b0;
      2'b01, 2'b10: e.less = ($signed(a_v) < $signed(b_v));
      default:      e.less = (a_v < b_v);
    endcase
    e.result = op_v[1] ? {31'b0, e.less} : full[31:0];
    e.zero   = (e.result == 32'b0);
    e.acc    = 0;
    return e;
  endfunction

  // Present one operation, wait (bounded) for acceptance, push expectation.
  task automatic drive(input logic [1:0] op_v, input logic [31:0] a_v,
                       input logic [31:0] b_v, input logic cin_v);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    out_ready = 1'b1;
    op = op_v; a = a_v; b = b_v; cin = cin_v; in_valid = 1'b1;
    got = 0;
    last_wait = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
      last_wait++;
    end
    if (!got) begin
      check("accept_timeout", 32'(got), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e = model(op_v, a_v, b_v, cin_v);
    e.acc = cyc;
    last_acc = cyc;
    sb_q.push_back(e);
    // Scramble inputs after accept; they must not affect the result.
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3)); cin = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  // Output monitor: latency on out_valid rise, field compare on handshake.
  logic last_vld = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && !last_vld && sb_q.size() > 0)
      check("latency", 32'(cyc - sb_q[0].acc), 32'd8);
    if (rst_n && out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("result",   result,   e.result);
        check("carry",    32'(carry),    32'(e.carry));
        check("overflow", 32'(overflow), 32'(e.overflow));
        check("less",     32'(less),     32'(e.less));
        check("zero",     32'(zero),     32'(e.zero));
      end
    end
    last_vld = out_valid;
  end

  initial begin
    int acc1;
    int t0;
    bit got;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = 2'b00; cin = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; op8 = 2'b00; cin8 = 1'b0;
    #2;
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    result, 32'd0);
    check("rst_flags",     32'({carry, overflow, less, zero}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed cases
    drive(2'b00, 32'h7FFF_FFFF, 32'd1, 1'b0); drain();
    drive(2'b01, 32'd5, 32'd5, 1'b0);         drain();
    drive(2'b10, 32'hFFFF_FFFF, 32'd1, 1'b0); drain();
    drive(2'b11, 32'hFFFF_FFFF, 32'd1, 1'b0); drain();
    drive(2'b00, 32'hFFFF_FFFF, 32'd0, 1'b1); drain();
    drive(2'b01, 32'd3, 32'd1, 1'b1);         drain();

    // Random mix
    for (int i = 0; i < 8; i++) begin
      drive(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      drain();
    end

    // Back-to-back throughput with out_ready high
    drive(2'b00, 32'd1, 32'd2, 1'b0);
    acc1 = last_acc;
    drive(2'b01, 32'd9, 32'd4, 1'b0);
    check("throughput", 32'(last_acc - acc1), 32'd9);
    drain();

    // Backpressure: result frozen in DONE, in_valid ignored
    drive(2'b00, 32'd100, 32'd23, 1'b0);
    out_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; break; end
    end
    check("bp_valid_seen", 32'(got), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid; a = $urandom; op = 2'b01;
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid",    32'(out_valid), 32'd1);
      check("bp_result",   result, 32'd123);
    end
    drive(2'b01, 32'd50, 32'd8, 1'b0);
    check("bp_same_cycle", 32'(last_wait), 32'd0);
    drain();

    // Reset during RUN at k=3
    drive(2'b00, 32'd1234, 32'd5678, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("mid_rst_in_ready",  32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_result",    result, 32'd0);
    check("mid_rst_flags",     32'({carry, overflow, less, zero}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    drive(2'b00, 32'd10, 32'd20, 1'b0);
    check("post_rst_expect", sb_q[0].result, 32'd30);
    drain();

    // 8-bit / 2-bit-digit instance: SUB 0x80 - 1
    @(posedge clk); #1;
    op8 = 2'b01; a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1;
    @(negedge clk);
    check("w8_in_ready", 32'(in_ready8), 32'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'h3C; b8 = 8'hA5;
    t0 = cyc;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid8) begin got = 1; break; end
    end
    check("w8_valid_seen", 32'(got), 32'd1);
    check("w8_latency",  32'(cyc - t0), 32'd4);
    check("w8_result",   32'(result8), 32'h7F);
    check("w8_overflow", 32'(overflow8), 32'd1);
    check("w8_carry",    32'(carry8), 32'd1);
    check("w8_less",     32'(less8), 32'd1);
    check("w8_zero",     32'(zero8), 32'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
